id_ex_stage_reg: RTL and testbench
==================================

Name: id_ex_stage_reg

Overview:
ID/EX pipeline register of the 32-bit ARM core, directly downstream of the register file.
- Captures reg1/reg2 and the decoded controls at the end of ID.
- Owns load-use/RAW hazard detection. It tracks the EX destination (its own outputs) and a one-entry MEM-stage shadow, stalls ID when a source is pending, and inserts bubbles on hazard or branch flush.

Parameters:
WORD_WIDTH, 32, datapath / PC width
REG_ADDR_W, 4, register index width (16 registers)
CMD_W, 4, EX command width

Ports:
clk  in  1  clock, all state updates on posedge
rst  in  1  synchronous, active-high reset
freeze  in  1  memory-stall hold; all state holds
flush  in  1  branch taken in EX; ID slot becomes bubble
id_valid  in  1  ID holds a real instruction
id_pc  in  WORD_WIDTH  PC+4 of ID instruction
reg1, reg2  in  WORD_WIDTH  register-file read data (Rn, Rm)
src1, src2  in  REG_ADDR_W  source indices driving the register file
two_src  in  1  src2 is a true operand (register Rm or store data)
id_dest  in  REG_ADDR_W  destination index
id_wb_en, id_mem_r_en, id_mem_w_en, id_b, id_s, id_imm  in  1 each  decoded controls
id_exe_cmd  in  CMD_W  ALU command
id_shift_operand  in  12  shifter operand field
id_signed_imm_24  in  24  branch offset
id_status  in  4  NZCV flags seen by ID
hazard  out  1  combinational stall request to IF/ID
ex_valid  out  1  EX holds a real instruction
ex_pc, ex_val_rn, ex_val_rm  out  WORD_WIDTH  registered copies
ex_src1, ex_src2, ex_dest  out  REG_ADDR_W  registered copies, src1/src2 kept for forwarding
ex_wb_en, ex_mem_r_en, ex_mem_w_en, ex_b, ex_s, ex_imm, ex_exe_cmd, ex_shift_operand, ex_signed_imm_24, ex_status  out  as inputs  registered controls

Behaviour:
- Reset (posedge clk with rst=1): every ex_* output = 0; MEM shadow {mem_valid, mem_wb_en, mem_dest} = 0. Reset mid-stall drops the held instruction.
- hazard, combinational:
  - match(s) = (ex_valid & ex_wb_en & ex_dest==s) | (mem_valid & mem_wb_en & mem_dest==s).
  - hazard = id_valid & ~flush & (match(src1) | (two_src & match(src2))).
- No WB-stage check: the register file writes on negedge, so a WB result is visible in reg1/reg2 in the same cycle.
- Posedge update, priority order:
  - rst.
  - freeze: hold all ex_* and the MEM shadow unchanged; hazard is still driven from held state.
  - Otherwise the MEM shadow loads {ex_valid, ex_wb_en, ex_dest}.
  - ID/EX then becomes a bubble if flush | hazard | ~id_valid. A bubble has ex_valid=0, all enables (wb/mem_r/mem_w/b/s) = 0, and all other fields = 0.
  - Else ID/EX captures all id_* / reg / src fields, with ex_valid=1.
- Latency: 1 cycle ID -> EX.
- RAW on the EX instruction: 2 stall cycles (EX match, then MEM match). RAW on the MEM instruction: 1 stall cycle.
- flush and hazard together: flush wins, hazard is 0, bubble inserted.
- A flush does not clear the MEM shadow: the branch in EX still advances.
- A stalled instruction re-presents identical id_* values (IF/ID holds); this block just re-evaluates each cycle.
- R15 handled like any index; no special casing.

Decomposition:
- The widths go in the shared constants header already used by the core: WORD_WIDTH, REG_FILE_DEPTH (register address width), EXE_CMD_LEN, SHIFT_OPERAND_LEN, SIGNED_IMM_LEN.
- One natural sub-module: hazard_detect. It is purely combinational: match logic from src1, src2, two_src, the EX fields and the MEM shadow fields.

Test Plan:
- Reset: rst=1 one cycle with arbitrary inputs -> all ex_* = 0 and hazard = 0 next cycle.
- Pass-through: id_valid=1, src1=2, src2=3, reg1=0x11, reg2=0x22, id_dest=4, id_wb_en=1, no pending writes -> next cycle ex_valid=1, ex_val_rn=0x11, ex_val_rm=0x22, ex_dest=4, hazard=0.
- EX RAW: ADD R4 then SUB with src1=4 -> hazard=1 for 2 cycles with bubbles (ex_valid=0) in EX. Third cycle: hazard=0 and SUB captured.
- two_src gating: EX dest=5 with wb_en; ID src2=5. two_src=0 -> hazard=0. two_src=1 -> hazard=1.
- Flush vs hazard: pending match and flush=1 together -> hazard=0, next ex_valid=0, and the MEM shadow takes the prior EX.
- Freeze: freeze=1 for 3 cycles while inputs change -> ex_* and hazard stay constant. freeze=0 -> normal update resumes.

Source files
------------

// File: rtl/id_ex_stage_reg_pkg.sv
// Shared core widths for the ID/EX stage, plus the destination-match helper
// used by the hazard logic.
package id_ex_stage_reg_pkg;

    localparam int WORD_WIDTH        = 32;
    localparam int REG_FILE_DEPTH    = 4;
    localparam int EXE_CMD_LEN       = 4;
    localparam int SHIFT_OPERAND_LEN = 12;
    localparam int SIGNED_IMM_LEN    = 24;
    localparam int STATUS_LEN        = 4;

    // True when a pending writer (valid, writing back) targets source index src.
    function automatic logic dest_match(
        input logic                      valid,
        input logic                      wb_en,
        input logic [REG_FILE_DEPTH-1:0] dest,
        input logic [REG_FILE_DEPTH-1:0] src
    );
        return valid & wb_en & (dest == src);
    endfunction

endpackage

// File: rtl/id_ex_stage_reg_hazard_detect.sv
// Combinational RAW detector: compares ID sources against the EX instruction
// and the one-entry MEM shadow; flush suppresses the stall.
module hazard_detect
    import id_ex_stage_reg_pkg::*;
(
    input  logic                      id_valid,
    input  logic                      flush,
    input  logic [REG_FILE_DEPTH-1:0] src1,
    input  logic [REG_FILE_DEPTH-1:0] src2,
    input  logic                      two_src,
    input  logic                      ex_valid,
    input  logic                      ex_wb_en,
    input  logic [REG_FILE_DEPTH-1:0] ex_dest,
    input  logic                      mem_valid,
    input  logic                      mem_wb_en,
    input  logic [REG_FILE_DEPTH-1:0] mem_dest,
    output logic                      hazard
);

    logic match1_s;
    logic match2_s;

    // Source match against EX and MEM writers, gated by operand use and flush.
    always_comb begin
        match1_s = dest_match(ex_valid, ex_wb_en, ex_dest, src1)
                 | dest_match(mem_valid, mem_wb_en, mem_dest, src1);
        match2_s = dest_match(ex_valid, ex_wb_en, ex_dest, src2)
                 | dest_match(mem_valid, mem_wb_en, mem_dest, src2);
        if (id_valid && !flush) begin
            hazard = match1_s | (two_src & match2_s);
        end else begin
            hazard = 1'b0;
        end
    end

endmodule

// File: rtl/id_ex_stage_reg.sv
// ID/EX pipeline register: captures operands and decoded controls, tracks the
// EX/MEM writers and stalls ID on a RAW hazard, inserting bubbles on stall or flush.
module id_ex_stage_reg #(
    parameter int WORD_WIDTH = id_ex_stage_reg_pkg::WORD_WIDTH,
    parameter int REG_ADDR_W = id_ex_stage_reg_pkg::REG_FILE_DEPTH,
    parameter int CMD_W      = id_ex_stage_reg_pkg::EXE_CMD_LEN
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  freeze,
    input  logic                  flush,
    input  logic                  id_valid,
    input  logic [WORD_WIDTH-1:0] id_pc,
    input  logic [WORD_WIDTH-1:0] reg1,
    input  logic [WORD_WIDTH-1:0] reg2,
    input  logic [REG_ADDR_W-1:0] src1,
    input  logic [REG_ADDR_W-1:0] src2,
    input  logic                  two_src,
    input  logic [REG_ADDR_W-1:0] id_dest,
    input  logic                  id_wb_en,
    input  logic                  id_mem_r_en,
    input  logic                  id_mem_w_en,
    input  logic                  id_b,
    input  logic                  id_s,
    input  logic                  id_imm,
    input  logic [CMD_W-1:0]      id_exe_cmd,
    input  logic [11:0]           id_shift_operand,
    input  logic [23:0]           id_signed_imm_24,
    input  logic [3:0]            id_status,
    output logic                  hazard,
    output logic                  ex_valid,
    output logic [WORD_WIDTH-1:0] ex_pc,
    output logic [WORD_WIDTH-1:0] ex_val_rn,
    output logic [WORD_WIDTH-1:0] ex_val_rm,
    output logic [REG_ADDR_W-1:0] ex_src1,
    output logic [REG_ADDR_W-1:0] ex_src2,
    output logic [REG_ADDR_W-1:0] ex_dest,
    output logic                  ex_wb_en,
    output logic                  ex_mem_r_en,
    output logic                  ex_mem_w_en,
    output logic                  ex_b,
    output logic                  ex_s,
    output logic                  ex_imm,
    output logic [CMD_W-1:0]      ex_exe_cmd,
    output logic [11:0]           ex_shift_operand,
    output logic [23:0]           ex_signed_imm_24,
    output logic [3:0]            ex_status
);

    logic                  ex_valid_r;
    logic [WORD_WIDTH-1:0] ex_pc_r;
    logic [WORD_WIDTH-1:0] ex_val_rn_r;
    logic [WORD_WIDTH-1:0] ex_val_rm_r;
    logic [REG_ADDR_W-1:0] ex_src1_r;
    logic [REG_ADDR_W-1:0] ex_src2_r;
    logic [REG_ADDR_W-1:0] ex_dest_r;
    logic                  ex_wb_en_r;
    logic                  ex_mem_r_en_r;
    logic                  ex_mem_w_en_r;
    logic                  ex_b_r;
    logic                  ex_s_r;
    logic                  ex_imm_r;
    logic [CMD_W-1:0]      ex_exe_cmd_r;
    logic [11:0]           ex_shift_operand_r;
    logic [23:0]           ex_signed_imm_24_r;
    logic [3:0]            ex_status_r;
    logic                  mem_valid_r;
    logic                  mem_wb_en_r;
    logic [REG_ADDR_W-1:0] mem_dest_r;
    logic                  hazard_s;
    logic                  bubble_s;

    hazard_detect u_hazard_detect (
        .id_valid  (id_valid),
        .flush     (flush),
        .src1      (src1),
        .src2      (src2),
        .two_src   (two_src),
        .ex_valid  (ex_valid_r),
        .ex_wb_en  (ex_wb_en_r),
        .ex_dest   (ex_dest_r),
        .mem_valid (mem_valid_r),
        .mem_wb_en (mem_wb_en_r),
        .mem_dest  (mem_dest_r),
        .hazard    (hazard_s)
    );

    assign bubble_s = flush | hazard_s | ~id_valid;

    // Stage register and MEM shadow; freeze holds everything, bubbles zero the payload.
    always_ff @(posedge clk) begin
        if (rst) begin
            mem_valid_r        <= 1'b0;
            mem_wb_en_r        <= 1'b0;
            mem_dest_r         <= '0;
            ex_valid_r         <= 1'b0;
            ex_pc_r            <= '0;
            ex_val_rn_r        <= '0;
            ex_val_rm_r        <= '0;
            ex_src1_r          <= '0;
            ex_src2_r          <= '0;
            ex_dest_r          <= '0;
            ex_wb_en_r         <= 1'b0;
            ex_mem_r_en_r      <= 1'b0;
            ex_mem_w_en_r      <= 1'b0;
            ex_b_r             <= 1'b0;
            ex_s_r             <= 1'b0;
            ex_imm_r           <= 1'b0;
            ex_exe_cmd_r       <= '0;
            ex_shift_operand_r <= 12'h000;
            ex_signed_imm_24_r <= 24'h000000;
            ex_status_r        <= 4'h0;
        end else if (!freeze) begin
            // The EX instruction always advances, even when a branch flushes ID.
            mem_valid_r <= ex_valid_r;
            mem_wb_en_r <= ex_wb_en_r;
            mem_dest_r  <= ex_dest_r;
            if (bubble_s) begin
                ex_valid_r         <= 1'b0;
                ex_pc_r            <= '0;
                ex_val_rn_r        <= '0;
                ex_val_rm_r        <= '0;
                ex_src1_r          <= '0;
                ex_src2_r          <= '0;
                ex_dest_r          <= '0;
                ex_wb_en_r         <= 1'b0;
                ex_mem_r_en_r      <= 1'b0;
                ex_mem_w_en_r      <= 1'b0;
                ex_b_r             <= 1'b0;
                ex_s_r             <= 1'b0;
                ex_imm_r           <= 1'b0;
                ex_exe_cmd_r       <= '0;
                ex_shift_operand_r <= 12'h000;
                ex_signed_imm_24_r <= 24'h000000;
                ex_status_r        <= 4'h0;
            end else begin
                ex_valid_r         <= 1'b1;
                ex_pc_r            <= id_pc;
                ex_val_rn_r        <= reg1;
                ex_val_rm_r        <= reg2;
                ex_src1_r          <= src1;
                ex_src2_r          <= src2;
                ex_dest_r          <= id_dest;
                ex_wb_en_r         <= id_wb_en;
                ex_mem_r_en_r      <= id_mem_r_en;
                ex_mem_w_en_r      <= id_mem_w_en;
                ex_b_r             <= id_b;
                ex_s_r             <= id_s;
                ex_imm_r           <= id_imm;
                ex_exe_cmd_r       <= id_exe_cmd;
                ex_shift_operand_r <= id_shift_operand;
                ex_signed_imm_24_r <= id_signed_imm_24;
                ex_status_r        <= id_status;
            end
        end
    end

    assign hazard           = hazard_s;
    assign ex_valid         = ex_valid_r;
    assign ex_pc            = ex_pc_r;
    assign ex_val_rn        = ex_val_rn_r;
    assign ex_val_rm        = ex_val_rm_r;
    assign ex_src1          = ex_src1_r;
    assign ex_src2          = ex_src2_r;
    assign ex_dest          = ex_dest_r;
    assign ex_wb_en         = ex_wb_en_r;
    assign ex_mem_r_en      = ex_mem_r_en_r;
    assign ex_mem_w_en      = ex_mem_w_en_r;
    assign ex_b             = ex_b_r;
    assign ex_s             = ex_s_r;
    assign ex_imm           = ex_imm_r;
    assign ex_exe_cmd       = ex_exe_cmd_r;
    assign ex_shift_operand = ex_shift_operand_r;
    assign ex_signed_imm_24 = ex_signed_imm_24_r;
    assign ex_status        = ex_status_r;

endmodule

// File: tb/tb_id_ex_stage_reg.sv
// Directed-vector bench for id_ex_stage_reg: reset, pass-through, EX/MEM RAW
// stalls, two_src gating, flush priority, freeze hold and reset mid-stall.
module tb_id_ex_stage_reg;

    logic        clk = 1'b0;
    logic        rst, freeze, flush, id_valid, two_src;
    logic [31:0] id_pc, reg1, reg2;
    logic [3:0]  src1, src2, id_dest;
    logic        id_wb_en, id_mem_r_en, id_mem_w_en, id_b, id_s, id_imm;
    logic [3:0]  id_exe_cmd, id_status;
    logic [11:0] id_shift_operand;
    logic [23:0] id_signed_imm_24;
    logic        hazard, ex_valid;
    logic [31:0] ex_pc, ex_val_rn, ex_val_rm;
    logic [3:0]  ex_src1, ex_src2, ex_dest;
    logic        ex_wb_en, ex_mem_r_en, ex_mem_w_en, ex_b, ex_s, ex_imm;
    logic [3:0]  ex_exe_cmd, ex_status;
    logic [11:0] ex_shift_operand;
    logic [23:0] ex_signed_imm_24;

    int n_checks = 0;
    int n_fails  = 0;

    always #5 clk = ~clk;

    id_ex_stage_reg dut (
        .clk(clk), .rst(rst), .freeze(freeze), .flush(flush), .id_valid(id_valid),
        .id_pc(id_pc), .reg1(reg1), .reg2(reg2), .src1(src1), .src2(src2),
        .two_src(two_src), .id_dest(id_dest), .id_wb_en(id_wb_en),
        .id_mem_r_en(id_mem_r_en), .id_mem_w_en(id_mem_w_en), .id_b(id_b),
        .id_s(id_s), .id_imm(id_imm), .id_exe_cmd(id_exe_cmd),
        .id_shift_operand(id_shift_operand), .id_signed_imm_24(id_signed_imm_24),
        .id_status(id_status), .hazard(hazard), .ex_valid(ex_valid), .ex_pc(ex_pc),
        .ex_val_rn(ex_val_rn), .ex_val_rm(ex_val_rm), .ex_src1(ex_src1),
        .ex_src2(ex_src2), .ex_dest(ex_dest), .ex_wb_en(ex_wb_en),
        .ex_mem_r_en(ex_mem_r_en), .ex_mem_w_en(ex_mem_w_en), .ex_b(ex_b),
        .ex_s(ex_s), .ex_imm(ex_imm), .ex_exe_cmd(ex_exe_cmd),
        .ex_shift_operand(ex_shift_operand), .ex_signed_imm_24(ex_signed_imm_24),
        .ex_status(ex_status)
    );

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Advance one clock; outputs are sampled 1 ns after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_id();
        id_valid = 1'b0; id_pc = 32'h0; reg1 = 32'h0; reg2 = 32'h0;
        src1 = 4'h0; src2 = 4'h0; two_src = 1'b0; id_dest = 4'h0;
        id_wb_en = 1'b0; id_mem_r_en = 1'b0; id_mem_w_en = 1'b0;
        id_b = 1'b0; id_s = 1'b0; id_imm = 1'b0; id_exe_cmd = 4'h0;
        id_shift_operand = 12'h000; id_signed_imm_24 = 24'h000000; id_status = 4'h0;
    endtask

    // Present a writing instruction: sources s1/s2, destination d, Rn data r1.
    task automatic present(input logic [3:0] s1, input logic [3:0] s2, input logic ts,
                           input logic [3:0] d, input logic [31:0] r1);
        idle_id();
        id_valid = 1'b1; src1 = s1; src2 = s2; two_src = ts;
        id_dest = d; id_wb_en = 1'b1; reg1 = r1;
        #1;
    endtask

    initial begin
        freeze = 1'b0; flush = 1'b0;
        // Reset with arbitrary live inputs
        rst = 1'b1;
        present(4'h2, 4'h3, 1'b1, 4'h9, 32'hDEAD_BEEF);
        id_pc = 32'h1234; id_b = 1'b1;
        tick();
        check_val("rst_ex_valid", ex_valid, 1'b0);
        check_val("rst_ex_val_rn", ex_val_rn, 32'h0);
        check_val("rst_ex_pc", ex_pc, 32'h0);
        check_val("rst_ex_dest", ex_dest, 4'h0);
        check_val("rst_ex_ctrl", {ex_wb_en, ex_b}, 2'b00);
        check_val("rst_hazard", hazard, 1'b0);
        rst = 1'b0;

        // Pass-through, no pending writers
        present(4'h2, 4'h3, 1'b1, 4'h4, 32'h11);
        reg2 = 32'h22; id_pc = 32'h100; id_mem_r_en = 1'b1; id_s = 1'b1; id_imm = 1'b1;
        id_exe_cmd = 4'h4; id_shift_operand = 12'hABC; id_signed_imm_24 = 24'h123456;
        id_status = 4'hA;
        #1;
        check_val("pt_hazard", hazard, 1'b0);
        tick();
        check_val("pt_ex_valid", ex_valid, 1'b1);
        check_val("pt_rn_rm", {ex_val_rn, ex_val_rm}, {32'h11, 32'h22});
        check_val("pt_dest_srcs", {ex_dest, ex_src1, ex_src2}, {4'h4, 4'h2, 4'h3});
        check_val("pt_pc", ex_pc, 32'h100);
        check_val("pt_ctrl", {ex_wb_en, ex_mem_r_en, ex_mem_w_en, ex_b, ex_s, ex_imm}, 6'b110011);
        check_val("pt_fields", {ex_exe_cmd, ex_shift_operand, ex_signed_imm_24, ex_status},
                  {4'h4, 12'hABC, 24'h123456, 4'hA});

        // EX RAW: SUB reads R4 written by the ADD now in EX -> 2 stalls
        present(4'h4, 4'h1, 1'b1, 4'h5, 32'h33);
        check_val("exraw_h0", hazard, 1'b1);
        tick();
        check_val("exraw_bubble0", {ex_valid, ex_wb_en, ex_dest}, 6'b0);
        check_val("exraw_h1", hazard, 1'b1);
        tick();
        check_val("exraw_bubble1", ex_valid, 1'b0);
        check_val("exraw_h2", hazard, 1'b0);
        tick();
        check_val("exraw_capture", {ex_valid, ex_dest, ex_val_rn}, {1'b1, 4'h5, 32'h33});

        // two_src gating against EX dest R5
        present(4'h0, 4'h5, 1'b0, 4'h0, 32'h0);
        check_val("twosrc0", hazard, 1'b0);
        two_src = 1'b1; #1;
        check_val("twosrc1", hazard, 1'b1);

        // MEM RAW: one idle cycle moves R5 writer to MEM -> 1 stall
        idle_id();
        tick();
        present(4'h5, 4'h0, 1'b0, 4'h6, 32'h55);
        check_val("memraw_h0", hazard, 1'b1);
        tick();
        check_val("memraw_bubble", ex_valid, 1'b0);
        check_val("memraw_h1", hazard, 1'b0);
        tick();
        check_val("memraw_capture", {ex_valid, ex_dest, ex_val_rn}, {1'b1, 4'h6, 32'h55});

        // Flush beats hazard; MEM shadow still takes the EX writer of R6
        present(4'h6, 4'h0, 1'b0, 4'h8, 32'h66);
        flush = 1'b1; #1;
        check_val("flush_hazard", hazard, 1'b0);
        tick();
        flush = 1'b0; #1;
        check_val("flush_bubble", ex_valid, 1'b0);
        check_val("flush_mem_shadow", hazard, 1'b1);
        tick();
        check_val("flush_drain", hazard, 1'b0);

        // Freeze: EX holds R7 writer, ID reads R7, inputs churn
        present(4'h1, 4'h0, 1'b0, 4'h7, 32'h44);
        id_pc = 32'h200; id_mem_w_en = 1'b1; id_b = 1'b1;
        tick();
        check_val("frz_load", {ex_valid, ex_mem_w_en, ex_b, ex_dest}, {3'b111, 4'h7});
        present(4'h7, 4'h0, 1'b0, 4'h9, 32'h0);
        freeze = 1'b1;
        for (int i = 0; i < 3; i++) begin
            reg1 = 32'h900 + 32'(i); id_pc = 32'h300 + 32'(i); id_dest = 4'(i);
            #1;
            check_val("frz_hazard", hazard, 1'b1);
            tick();
            check_val("frz_hold", {ex_pc, ex_val_rn, ex_dest}, {32'h200, 32'h44, 4'h7});
        end
        freeze = 1'b0; #1;
        check_val("frz_resume_h", hazard, 1'b1);
        tick();
        check_val("frz_resume_bubble", ex_valid, 1'b0);
        check_val("frz_resume_mem", hazard, 1'b1);

        // Reset mid-stall drops the held instruction and clears the shadow
        rst = 1'b1;
        tick();
        rst = 1'b0; #1;
        check_val("rst_stall_hazard", hazard, 1'b0);
        check_val("rst_stall_valid", ex_valid, 1'b0);

        // R15 is an ordinary index
        present(4'h0, 4'h0, 1'b0, 4'hF, 32'h15);
        tick();
        present(4'h1, 4'hF, 1'b1, 4'h2, 32'h0);
        check_val("r15_hazard", hazard, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
